// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions.
//   - 4-bit ALU control codes seen by the stages downstream of the ALU
//   - state encoding for the memory-access stage
//   - packed writeback bundle handed from the memory stage to writeback
package mips_pkg;

  localparam logic [3:0] ALU_SW    = 4'b0001;
  localparam logic [3:0] ALU_ADDU  = 4'b0010;
  localparam logic [3:0] ALU_ADDIU = 4'b0011;
  localparam logic [3:0] ALU_LW    = 4'b0100;
  localparam logic [3:0] ALU_JAL   = 4'b0101;
  localparam logic [3:0] ALU_OR    = 4'b0110;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } stage_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        reg_write;
  } wb_bundle_t;

  // Only lw and sw touch data memory; every other code is a pass-through.
  function automatic logic is_mem_op(input logic [3:0] ctrl);
    return (ctrl == ALU_LW) || (ctrl == ALU_SW);
  endfunction

endpackage

// File: rtl/mem_access_stage.sv
// Memory-access stage sitting directly after the ALU.
// Non-memory operations retire one cycle after acceptance with the ALU
// result. Aligned lw/sw run a single req/ack transaction to data memory
// while the stage stalls upstream; misaligned accesses and accesses that
// see no ack within TIMEOUT_CYCLES retire with a flag and no register write.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  upstream handshake (in_ready is high only in IDLE)
//   in_ctrl         ALU control code, in_result ALU result / address
//   in_store_data   sw data, in_dest / in_reg_write writeback target
//   mem_req/we/addr/wdata, mem_ack/rdata  data memory request interface
//   out_valid       one-cycle retire pulse with out_data/out_dest/out_reg_write
//   misalign        retire flag: lw/sw address not word aligned
//   timeout         retire flag: access abandoned without ack
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_ctrl,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_dest,
  input  logic        in_reg_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_dest,
  output logic        out_reg_write,
  output logic        misalign,
  output logic        timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  stage_state_e     state;
  logic [CNT_W-1:0] cnt;
  wb_bundle_t       wb_p1;

  // Operation attributes held for the duration of an access.
  logic [4:0]       dest_p0;
  logic             rw_p0;
  logic             is_lw_p0;

  logic accept;
  logic mem_op;
  logic aligned;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign mem_op   = is_mem_op(in_ctrl);
  assign aligned  = (in_result[1:0] == 2'b00);

  assign out_data      = wb_p1.data;
  assign out_dest      = wb_p1.dest;
  assign out_reg_write = wb_p1.reg_write;

  // Stage 0 -> stage 1: accept, run the memory access, produce the retire bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      out_valid <= 1'b0;
      misalign  <= 1'b0;
      timeout   <= 1'b0;
      wb_p1     <= '0;
    end else begin
      out_valid <= 1'b0;
      misalign  <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!mem_op) begin
              out_valid <= 1'b1;
              wb_p1     <= '{data: in_result, dest: in_dest, reg_write: in_reg_write};
            end else if (!aligned) begin
              out_valid <= 1'b1;
              misalign  <= 1'b1;
              wb_p1     <= '{data: in_result, dest: in_dest, reg_write: 1'b0};
            end else begin
              state     <= ST_ACCESS;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= (in_ctrl == ALU_SW);
              mem_addr  <= in_result;
              mem_wdata <= in_store_data;
            end
          end
        end
        ST_ACCESS: begin
          // An ack on the final allowed cycle still completes the access.
          if (mem_ack) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            out_valid <= 1'b1;
            wb_p1     <= '{data:      is_lw_p0 ? mem_rdata : mem_addr,
                           dest:      dest_p0,
                           reg_write: is_lw_p0 && rw_p0};
          end else if (cnt == CNT_LAST) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            out_valid <= 1'b1;
            timeout   <= 1'b1;
            wb_p1     <= '{data: mem_addr, dest: dest_p0, reg_write: 1'b0};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Attribute capture has no reset; it is only consumed in ACCESS, which is
  // entered exactly when these registers load.
  always_ff @(posedge clk) begin
    if (accept && mem_op && aligned) begin
      dest_p0  <= in_dest;
      rw_p0    <= in_reg_write;
      is_lw_p0 <= (in_ctrl == ALU_LW);
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int TO = 16;
  localparam logic [3:0] C_LW   = 4'b0100;
  localparam logic [3:0] C_SW   = 4'b0001;
  localparam logic [3:0] C_ADDU = 4'b0010;
  localparam logic [3:0] C_JAL  = 4'b0101;
  localparam logic [3:0] C_OR   = 4'b0110;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_ctrl;
  logic [31:0] in_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_dest;
  logic        in_reg_write;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_dest;
  logic        out_reg_write;
  logic        misalign;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_result(in_result), .in_store_data(in_store_data),
    .in_dest(in_dest), .in_reg_write(in_reg_write),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_dest(out_dest),
    .out_reg_write(out_reg_write), .misalign(misalign), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation_time_limit got=expired required=finish");
    $fatal(1, "watchdog");
  end

  // Reference behaviour for one operation, starting and ending at a negedge.
  // d = index of the request cycle on which memory acks (d >= TO: never).
  task automatic do_op(input logic [3:0] c, input logic [31:0] r, input logic [31:0] sd,
                       input logic [4:0] dst, input logic rw, input int d,
                       input logic [31:0] rd, input string tag);
    logic is_lw, is_sw, to;
    int   ncyc;
    is_lw = (c == C_LW);
    is_sw = (c == C_SW);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s in_ready_idle got=%b exp=1", tag, in_ready);
    end
    in_valid = 1'b1; in_ctrl = c; in_result = r; in_store_data = sd;
    in_dest = dst; in_reg_write = rw;
    @(negedge clk);
    in_valid = 1'b0; in_ctrl = 4'($urandom); in_result = $urandom;
    in_store_data = $urandom; in_dest = 5'($urandom); in_reg_write = 1'($urandom);
    if (!(is_lw || is_sw)) begin
      checks++;
      if ({out_valid, misalign, timeout, out_reg_write, mem_req} !== {3'b100, rw, 1'b0}) begin
        failures++;
        $display("FAIL %s pass_flags got=%b exp=%b", tag,
                 {out_valid, misalign, timeout, out_reg_write, mem_req}, {3'b100, rw, 1'b0});
      end
      checks++;
      if ({out_data, out_dest} !== {r, dst}) begin
        failures++;
        $display("FAIL %s pass_data got=%h/%0d exp=%h/%0d", tag, out_data, out_dest, r, dst);
      end
    end else if (r[1:0] != 2'b00) begin
      checks++;
      if ({out_valid, misalign, timeout, out_reg_write, mem_req, out_dest} !== {5'b11000, dst}) begin
        failures++;
        $display("FAIL %s misalign_flags got=%b exp=%b", tag,
                 {out_valid, misalign, timeout, out_reg_write, mem_req, out_dest}, {5'b11000, dst});
      end
    end else begin
      to   = (d >= TO);
      ncyc = to ? TO : d + 1;
      for (int k = 0; k < ncyc; k++) begin
        checks++;
        if ({mem_req, mem_we, in_ready, out_valid} !== {1'b1, is_sw, 2'b00}) begin
          failures++;
          $display("FAIL %s access_ctrl cyc=%0d got=%b exp=%b", tag, k,
                   {mem_req, mem_we, in_ready, out_valid}, {1'b1, is_sw, 2'b00});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== {r, sd}) begin
          failures++;
          $display("FAIL %s access_bus cyc=%0d got=%h/%h exp=%h/%h", tag, k,
                   mem_addr, mem_wdata, r, sd);
        end
        if (k == d) begin mem_ack = 1'b1; mem_rdata = rd; end
        else begin mem_ack = 1'b0; mem_rdata = $urandom; end
        @(negedge clk);
      end
      mem_ack = 1'b0;
      checks++;
      if ({mem_req, out_valid, misalign, timeout, out_reg_write, out_dest, in_ready}
          !== {3'b010, to, (is_lw && !to) ? rw : 1'b0, dst, 1'b1}) begin
        failures++;
        $display("FAIL %s retire_flags got=%b exp=%b", tag,
                 {mem_req, out_valid, misalign, timeout, out_reg_write, out_dest, in_ready},
                 {3'b010, to, (is_lw && !to) ? rw : 1'b0, dst, 1'b1});
      end
      if (!to) begin
        checks++;
        if (out_data !== (is_lw ? rd : r)) begin
          failures++;
          $display("FAIL %s retire_data got=%h exp=%h", tag, out_data, is_lw ? rd : r);
        end
      end
    end
  endtask

  // One idle cycle; also shows that the previous retire was a single pulse.
  task automatic idle_cycle(input string tag);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, misalign, timeout, mem_req, in_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL %s idle got=%b exp=00001", tag, {out_valid, misalign, timeout, mem_req, in_ready});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_result = '0; in_store_data = '0;
    in_dest = '0; in_reg_write = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, mem_req, mem_we, out_valid, misalign, timeout, out_reg_write} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset ctrl got=%b exp=1000000",
               {in_ready, mem_req, mem_we, out_valid, misalign, timeout, out_reg_write});
    end
    checks++;
    if ({mem_addr, mem_wdata, out_data, out_dest} !== '0) begin
      failures++;
      $display("FAIL reset data got=%h/%h/%h/%0d exp=0", mem_addr, mem_wdata, out_data, out_dest);
    end
  endtask

  task automatic test_passthrough();
    do_op(C_ADDU, 32'h0000_0010, 32'h0, 5'd5, 1'b1, 0, 32'h0, "addu");
    do_op(C_OR,   32'hA5A5_0003, 32'h0, 5'd7, 1'b1, 0, 32'h0, "b2b_or");
    do_op(C_JAL,  32'h0040_0008, 32'h0, 5'd31, 1'b1, 0, 32'h0, "b2b_jal");
    do_op(4'hF,   32'h1357_9BDF, 32'h0, 5'd2, 1'b0, 0, 32'h0, "b2b_undef");
    idle_cycle("pass_pulse");
  endtask

  task automatic test_lw_zero_wait();
    do_op(C_LW, 32'h0000_0040, 32'h0, 5'd9, 1'b1, 0, 32'hDEAD_BEEF, "lw0");
    do_op(C_ADDU, 32'h0000_0077, 32'h0, 5'd3, 1'b1, 0, 32'h0, "after_lw");
    idle_cycle("lw_pulse");
  endtask

  task automatic test_sw_wait();
    do_op(C_SW, 32'h0000_0080, 32'h1234_5678, 5'd4, 1'b1, 3, 32'h0, "sw3");
    idle_cycle("sw_pulse");
  endtask

  task automatic test_misalign();
    do_op(C_LW, 32'h0000_0042, 32'h0, 5'd8, 1'b1, 0, 32'h0, "lw_mis");
    do_op(C_SW, 32'h0000_0081, 32'h5555_AAAA, 5'd1, 1'b0, 0, 32'h0, "sw_mis");
    idle_cycle("mis_pulse");
  endtask

  task automatic test_timeout();
    do_op(C_LW, 32'h0000_0100, 32'h0, 5'd12, 1'b1, 1000, 32'h0, "lw_to");
    idle_cycle("to_pulse");
    do_op(C_LW, 32'h0000_0104, 32'h0, 5'd13, 1'b1, TO - 1, 32'hCAFE_F00D, "lw_lastack");
    do_op(C_SW, 32'h0000_0108, 32'h0BAD_0BAD, 5'd6, 1'b1, 1000, 32'h0, "sw_to");
    idle_cycle("to_pulse2");
  endtask

  task automatic test_idle_ack();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    idle_cycle("idle_ack1");
    idle_cycle("idle_ack2");
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    in_valid = 1'b1; in_ctrl = C_LW; in_result = 32'h0000_0200; in_dest = 5'd10; in_reg_write = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid pre_req got=%b exp=1", mem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    checks++;
    if ({mem_req, in_ready, out_valid} !== 3'b010) begin
      failures++;
      $display("FAIL rst_mid after_rst got=%b exp=010", {mem_req, in_ready, out_valid});
    end
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, in_ready, out_valid, timeout} !== 4'b0100) begin
      failures++;
      $display("FAIL rst_mid late_ack got=%b exp=0100", {mem_req, in_ready, out_valid, timeout});
    end
    idle_cycle("rst_mid_quiet");
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [31:0] r;
    int          d;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0, 2:    c = C_LW;
        1, 3:    c = C_SW;
        4:       c = C_ADDU;
        5:       c = C_JAL;
        6:       c = C_OR;
        default: c = 4'($urandom);
      endcase
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 4) : $urandom_range(0, 4);
      do_op(c, r, $urandom, 5'($urandom), 1'($urandom), d, $urandom, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) idle_cycle($sformatf("rnd_idle%0d", i));
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_lw_zero_wait();
    test_sw_wait();
    test_misalign();
    test_timeout();
    test_idle_ack();
    test_reset_mid_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the ALU in the MIPS datapath.
- Consumes the ALU control code and 32-bit ALU result. For lw/sw the result is the word address; the stage runs one request/acknowledge transaction to data memory.
- Every other operation passes the ALU result through to writeback with one register stage.
- Stalls upstream via in_ready while a memory transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles mem_req stays high without mem_ack before the access is abandoned (>=1).
- CNT_W, 5: width of the timeout counter (must hold TIMEOUT_CYCLES).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream operation present
- in_ready  output  1  stage can accept an operation this cycle
- in_ctrl  input  4  ALU control code (lw=4'b0100, sw=4'b0001, others non-memory)
- in_result  input  32  ALU result / memory address
- in_store_data  input  32  rt value for sw
- in_dest  input  5  destination register index
- in_reg_write  input  1  operation writes a register
- mem_req  output  1  memory request, held until mem_ack
- mem_we  output  1  1=store, 0=load
- mem_addr  output  32  word address (bits [1:0] always 0)
- mem_wdata  output  32  store data
- mem_ack  input  1  memory completes the request this cycle
- mem_rdata  input  32  load data, valid with mem_ack
- out_valid  output  1  one-cycle retire pulse to writeback
- out_data  output  32  writeback value
- out_dest  output  5  writeback register index
- out_reg_write  output  1  writeback enable (only meaningful with out_valid)
- misalign  output  1  pulse with out_valid: lw/sw address [1:0]!=0
- timeout  output  1  pulse with out_valid: access abandoned

Behaviour:
- Reset: state IDLE; counter 0; all outputs 0 except in_ready=1. Reset wins over every other event, including mid-access. A mem_ack arriving after reset is ignored.
- States: IDLE, ACCESS.
- IDLE: in_ready=1. Accept occurs when in_valid=1.
- Accepted non-memory op (any code other than lw/sw, including jal and undefined codes): next cycle out_valid=1, out_data=in_result, out_dest/out_reg_write copied. Stay IDLE; throughput is 1 op/cycle.
- Accepted lw/sw with in_result[1:0]!=0: no request issued. Next cycle out_valid=1, misalign=1, out_reg_write=0. Stay IDLE.
- Accepted aligned lw/sw: next cycle enter ACCESS with mem_req=1, mem_we=(sw), mem_addr=in_result, mem_wdata=in_store_data. Dest, reg_write and op are latched.
- ACCESS: in_ready=0. The mem_* outputs stay stable until completion. The counter increments every cycle mem_req=1 and mem_ack=0.
- mem_ack=1 in ACCESS: mem_req drops next cycle. Same next cycle, out_valid=1; for lw out_data=mem_rdata captured at ack and out_reg_write=latched flag; for sw out_reg_write=0 and out_data=address. Return to IDLE.
- Zero-wait latency: accept at T, mem_req at T+1, ack at T+1, out_valid at T+2, next accept at T+2.
- Counter reaching TIMEOUT_CYCLES-1 with mem_ack=0: next cycle mem_req=0, out_valid=1, timeout=1, out_reg_write=0, return to IDLE.
- If mem_ack and the timeout limit coincide, ack wins and timeout=0.
- out_valid, misalign and timeout are single-cycle pulses. Writeback never backpressures.
- mem_ack while in IDLE is ignored.

Decomposition:
- Shared package mips_pkg: 4-bit ALU control code constants (addiu, sw, addu, jal, lw, or), the stage state enum, and the typedef for a packed writeback bundle (data, dest, reg_write).
- No sub-module is needed; the counter and FSM stay inline.

Test Plan:
- addu, in_result=32'h0000_0010, dest=5, reg_write=1 -> next cycle out_valid=1, out_data=0x10, out_dest=5; back-to-back ops retire every cycle.
- lw addr=32'h0000_0040, mem_ack same cycle as req, mem_rdata=32'hDEAD_BEEF -> mem_addr=0x40, mem_we=0; out_valid two cycles after accept with out_data=0xDEADBEEF, out_reg_write=1.
- sw addr=0x80, data=32'h1234_5678, ack after 3 wait cycles -> mem_we=1 and mem_wdata stable for 4 cycles, in_ready=0 throughout, out_valid with out_reg_write=0.
- lw addr=32'h0000_0042 -> no mem_req; next cycle out_valid=1, misalign=1, out_reg_write=0.
- lw with mem_ack never asserted, TIMEOUT_CYCLES=16 -> mem_req high exactly 16 cycles, then out_valid=1, timeout=1; ack on cycle 16 instead -> timeout=0, data retired.
- rst=1 during ACCESS, then late mem_ack -> next cycle mem_req=0, in_ready=1, no out_valid generated.
